// File: rtl/lsu_mem_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// Memory-access stage between execute and writeback. Takes one load/store
// per request, checks funct3 legality and alignment, runs a single
// valid/ready transfer on a word-addressed data bus with byte-lane steering,
// and returns exactly one response (extended load data or a fault).
// A bus that never asserts mem_ready is converted into a fault after
// TIMEOUT cycles of mem_valid (TIMEOUT = 0 disables the watchdog).
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_store            1 = store, 0 = load
//   req_funct3           RV32I width code
//   req_addr             effective byte address
//   req_wdata            store data (rs2)
//   mem_valid/mem_ready  bus handshake; mem_rdata valid with mem_ready
//   mem_we               write enable
//   mem_addr             word-aligned bus address
//   mem_wstrb            byte write strobes (0000 on loads)
//   mem_wdata            lane-replicated store data
//   mem_rdata            read word
//   rsp_valid            one-cycle response pulse
//   rsp_rdata            extended load value (0 for stores / faults)
//   rsp_fault            misaligned, illegal funct3 or bus timeout
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t            state;
    state_t            state_next;

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;

    logic              req_illegal;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata_lanes;
    logic              bus_timeout;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [31:0]       load_value;

    assign req_ready = (state == S_IDLE);

    // Watchdog fires on the last permitted cycle without ready; a handshake
    // in the same cycle takes priority in the state logic below.
    assign bus_timeout = TO_EN && (cnt == CNT_LAST) && !mem_ready;

    // ------------------------------------------------------------------
    // Request decode: legality, alignment, store lane steering
    // ------------------------------------------------------------------
    always_comb begin
        req_illegal     = 1'b0;
        req_wstrb       = '0;
        req_wdata_lanes = req_wdata;
        if (req_store) begin
            case (req_funct3)
                3'b000: begin
                    req_wstrb       = 4'b0001 << req_addr[1:0];
                    req_wdata_lanes = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    req_wstrb       = 4'b0011 << req_addr[1:0];
                    req_wdata_lanes = {2{req_wdata[15:0]}};
                    req_illegal     = req_addr[0];
                end
                3'b010: begin
                    req_wstrb       = 4'b1111;
                    req_illegal     = |req_addr[1:0];
                end
                default: req_illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_illegal = 1'b0;
                3'b001, 3'b101: req_illegal = req_addr[0];
                3'b010:         req_illegal = |req_addr[1:0];
                default:        req_illegal = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the registered lane / width
    // ------------------------------------------------------------------
    always_comb begin
        case (lane_q)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_value = {{16{load_half[15]}}, load_half};
            3'b100:  load_value = {24'd0, load_byte};
            3'b101:  load_value = {16'd0, load_half};
            default: load_value = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = req_illegal ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (mem_ready || bus_timeout) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered bus and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            cnt       <= '0;
            funct3_q  <= '0;
            lane_q    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        lane_q   <= req_addr[1:0];
                        cnt      <= '0;
                        if (req_illegal) begin
                            // Fault without touching the bus
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wstrb <= req_store ? req_wstrb : 4'b0000;
                            mem_wdata <= req_wdata_lanes;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= mem_we ? 32'd0 : load_value;
                    end else if (bus_timeout) begin
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
`timescale 1ns/1ps
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in the cycle after acceptance.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) chk("idle_wait", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Legal access with mem_ready already high.
    task automatic access(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata);
        mem_ready = 1'b1;
        mem_rdata = rd;
        issue(st, f3, addr, wd);
        chk({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, ".mem_addr"}, mem_addr, exp_addr);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(st));
        chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
        if (st) chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        chk({tag, ".rsp_early"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".rsp_fault"}, 32'(rsp_fault), 32'd0);
        chk({tag, ".mem_drop"}, 32'(mem_valid), 32'd0);
        tick();
        chk({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_hold"}, rsp_rdata, exp_rdata);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic fault_req(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr);
        mem_ready = 1'b1;
        issue(st, f3, addr, 32'hFFFF_FFFF);
        chk({tag, ".no_bus"}, 32'(mem_valid), 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_fault"}, 32'(rsp_fault), 32'd1);
        chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
        tick();
        chk({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".no_bus2"}, 32'(mem_valid), 32'd0);
    endtask

    initial begin
        int hi_cycles;
        int k;

        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        chk("rst.mem_valid", 32'(mem_valid), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        resetn = 1'b1;
        tick();

        // Loads
        access("lb",  1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_1234,
               32'h8000_0000, 4'b0000, 32'd0, 32'hFFFF_FF80);
        access("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'hBEEF_0000,
               32'h8000_0000, 4'b0000, 32'd0, 32'h0000_BEEF);
        access("lh",  1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'hBEEF_0000,
               32'h8000_0000, 4'b0000, 32'd0, 32'hFFFF_BEEF);
        access("lbu", 1'b0, 3'b100, 32'h8000_0011, 32'd0, 32'h1122_9A44,
               32'h8000_0010, 4'b0000, 32'd0, 32'h0000_009A);
        access("lw",  1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'hCAFE_F00D,
               32'h8000_0020, 4'b0000, 32'd0, 32'hCAFE_F00D);

        // Stores
        access("sb",  1'b1, 3'b000, 32'h8000_0101, 32'h0000_00A5, 32'd0,
               32'h8000_0100, 4'b0010, 32'hA5A5_A5A5, 32'd0);
        access("sh",  1'b1, 3'b001, 32'h8000_0102, 32'h1234_BEEF, 32'd0,
               32'h8000_0100, 4'b1100, 32'hBEEF_BEEF, 32'd0);
        access("sw",  1'b1, 3'b010, 32'h8000_0104, 32'hDEAD_BEEF, 32'd0,
               32'h8000_0104, 4'b1111, 32'hDEAD_BEEF, 32'd0);

        // Faults
        fault_req("lw_mis",  1'b0, 3'b010, 32'h8000_0002);
        fault_req("ld_f110", 1'b0, 3'b110, 32'h8000_0000);
        fault_req("lh_mis",  1'b0, 3'b001, 32'h8000_0001);
        fault_req("st_f011", 1'b1, 3'b011, 32'h8000_0000);
        fault_req("sw_mis",  1'b1, 3'b010, 32'h8000_0001);

        // Timeout: ready never comes
        mem_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h8000_0200, 32'd0);
        hi_cycles = 0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 40) begin
            if (mem_valid === 1'b1) hi_cycles++;
            tick();
            k++;
        end
        chk("to.rsp_seen", 32'(rsp_valid), 32'd1);
        chk("to.hi_cycles", 32'(hi_cycles), 32'd16);
        chk("to.fault", 32'(rsp_fault), 32'd1);
        chk("to.rdata", rsp_rdata, 32'd0);
        chk("to.mem_drop", 32'(mem_valid), 32'd0);
        tick();

        // Ready arrives on the 16th (last) cycle: handshake beats timeout
        mem_ready = 1'b0;
        mem_rdata = 32'h1234_5678;
        issue(1'b0, 3'b010, 32'h8000_0300, 32'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("to16.mem_valid", 32'(mem_valid), 32'd1);
        chk("to16.no_rsp", 32'(rsp_valid), 32'd0);
        mem_ready = 1'b1;
        tick();
        chk("to16.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to16.fault", 32'(rsp_fault), 32'd0);
        chk("to16.rdata", rsp_rdata, 32'h1234_5678);
        tick();

        // Reset while the bus request is outstanding
        mem_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h8000_0400, 32'd0);
        tick();
        chk("rbus.in_bus", 32'(mem_valid), 32'd1);
        resetn = 1'b0;
        tick();
        chk("rbus.mem_valid", 32'(mem_valid), 32'd0);
        chk("rbus.rsp_valid", 32'(rsp_valid), 32'd0);
        resetn = 1'b1;
        tick();
        chk("rbus.req_ready", 32'(req_ready), 32'd1);
        hi_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid === 1'b1) hi_cycles++;
            tick();
        end
        chk("rbus.no_rsp", 32'(hi_cycles), 32'd0);

        // Back-to-back: second request held from the response cycle
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_00F0;
        issue(1'b0, 3'b100, 32'h8000_0500, 32'd0);
        tick();
        chk("b2b.rsp1", 32'(rsp_valid), 32'd1);
        chk("b2b.busy", 32'(req_ready), 32'd0);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h8000_0600;
        req_wdata  = 32'h0BAD_F00D;
        tick();
        chk("b2b.ready", 32'(req_ready), 32'd1);
        chk("b2b.not_yet", 32'(mem_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("b2b.mem_valid", 32'(mem_valid), 32'd1);
        chk("b2b.mem_addr", mem_addr, 32'h8000_0600);
        chk("b2b.mem_wdata", mem_wdata, 32'h0BAD_F00D);
        tick();
        chk("b2b.rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b.rdata2", rsp_rdata, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
